gb_lcd_stream_gen: RTL and testbench

PPU-side transmitter that produces the LCD pixel stream consumed by the scan-converter `lcd` block. It owns Game Boy line/frame timing (456 dots × 154 lines) and drives the 2-bit `mode` sequence. During mode 3 it pulls 2-bit pixels from the background/sprite mixer over a valid/ready handshake and emits each as a one-clock `lcd_clkena` strobe with `lcd_data`. It sits between the pixel mixer and `lcd`, and also supplies LY and a vblank IRQ to the register file.

---
 rtl/gb_lcd_stream_gen_pkg.sv | 17 +
 rtl/gb_lcd_stream_gen_if.sv | 10 +
 rtl/gb_lcd_stream_gen_dot_counter.sv | 39 +++
 rtl/gb_lcd_stream_gen.sv | 118 +++++++++++
 tb/tb_gb_lcd_stream_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_lcd_stream_gen_pkg.sv
// Shared timing constants and LCD mode encoding for the PPU stream generator
// and the downstream lcd scan converter.
package gb_lcd_pkg;
    localparam int LINE_DOTS = 456;
    localparam int LINES     = 154;
    localparam int VIS_LINES = 144;
    localparam int OAM_DOTS  = 80;
    localparam int H_PIXELS  = 160;
    localparam int PAD_START = 294;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'b00,
        MODE_VBLANK = 2'b01,
        MODE_OAM    = 2'b10,
        MODE_XFER   = 2'b11
    } lcd_mode_e;
endpackage

// File: rtl/gb_lcd_stream_gen_if.sv
// Pixel handshake between the background/sprite mixer (master) and the
// stream generator (slave).
interface gb_lcd_stream_gen_if;
    logic       pix_valid;
    logic [1:0] pix_data;
    logic       pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/gb_lcd_stream_gen_dot_counter.sv
// Dot/line position counters. dot/line point at the dot that the next ce
// will process; both clear whenever the LCD is switched off.
module gb_lcd_dot_counter
    import gb_lcd_pkg::*;
#(
    parameter int LINE_DOTS = gb_lcd_pkg::LINE_DOTS,
    parameter int LINES     = gb_lcd_pkg::LINES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       lcd_on,
    output logic [8:0] dot,
    output logic [7:0] line,
    output logic       line_end
);
    logic frame_end;

    assign line_end  = (dot == 9'(LINE_DOTS - 1));
    assign frame_end = line_end && (line == 8'(LINES - 1));

    // Advance one dot per ce, wrapping line and frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot  <= '0;
            line <= '0;
        end else if (!lcd_on) begin
            dot  <= '0;
            line <= '0;
        end else if (ce) begin
            if (line_end) begin
                dot  <= '0;
                line <= frame_end ? 8'd0 : line + 8'd1;
            end else begin
                dot <= dot + 9'd1;
            end
        end
    end
endmodule

// File: rtl/gb_lcd_stream_gen.sv
// PPU-side LCD stream generator: line/frame timing, mode sequencing and
// per-dot pixel emission toward the lcd scan converter.
//
// state        | meaning
// MODE_OAM     | visible line, dots 0..OAM_DOTS-1
// MODE_XFER    | visible line, emitting until H_PIXELS pixels are out
// MODE_HBLANK  | visible line after the last pixel; also idle/LCD off
// MODE_VBLANK  | lines VIS_LINES..LINES-1
//
// Registered outputs describe the dot processed on the last ce, so a strobe
// always coincides with mode XFER and the dot after the last pixel shows
// HBLANK. Emission is forced from PAD_START so XFER ends by dot 453.
module gb_lcd_stream_gen
    import gb_lcd_pkg::*;
#(
    parameter int LINE_DOTS = gb_lcd_pkg::LINE_DOTS,
    parameter int LINES     = gb_lcd_pkg::LINES,
    parameter int VIS_LINES = gb_lcd_pkg::VIS_LINES,
    parameter int OAM_DOTS  = gb_lcd_pkg::OAM_DOTS,
    parameter int H_PIXELS  = gb_lcd_pkg::H_PIXELS,
    parameter int PAD_START = gb_lcd_pkg::PAD_START
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                lcd_on,
    gb_lcd_stream_gen_if.slave  pix,
    output logic [1:0]          mode,
    output logic                lcd_clkena,
    output logic [1:0]          lcd_data,
    output logic [7:0]          ly,
    output logic                vblank_irq,
    output logic                underrun
);
    logic [8:0] dot;
    logic [7:0] line;
    logic       line_end;
    logic [7:0] pix_cnt;
    lcd_mode_e  mode_q;
    logic       visible;
    logic       emitting;
    logic       take;
    logic       pad;

    gb_lcd_dot_counter #(
        .LINE_DOTS (LINE_DOTS),
        .LINES     (LINES)
    ) u_dot_counter (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .lcd_on   (lcd_on),
        .dot      (dot),
        .line     (line),
        .line_end (line_end)
    );

    assign visible  = (line < 8'(VIS_LINES));
    assign emitting = lcd_on && visible && (dot >= 9'(OAM_DOTS)) && (pix_cnt < 8'(H_PIXELS));
    assign take     = ce && emitting && pix.pix_valid;
    assign pad      = ce && emitting && !pix.pix_valid && (dot >= 9'(PAD_START));

    assign pix.pix_ready = take;
    assign mode          = mode_q;

    // Mode FSM plus pixel strobe, LY, vblank pulse and sticky underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_HBLANK;
            pix_cnt    <= '0;
            lcd_clkena <= 1'b0;
            lcd_data   <= 2'b00;
            ly         <= '0;
            vblank_irq <= 1'b0;
            underrun   <= 1'b0;
        end else if (!lcd_on) begin
            mode_q     <= MODE_HBLANK;
            pix_cnt    <= '0;
            lcd_clkena <= 1'b0;
            lcd_data   <= 2'b00;
            ly         <= '0;
            vblank_irq <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            lcd_clkena <= 1'b0;
            vblank_irq <= 1'b0;
            if (ce) begin
                ly         <= line;
                vblank_irq <= (line == 8'(VIS_LINES)) && (dot == '0);

                if (!visible) begin
                    mode_q <= MODE_VBLANK;
                end else if (dot < 9'(OAM_DOTS)) begin
                    mode_q <= MODE_OAM;
                end else if (pix_cnt < 8'(H_PIXELS)) begin
                    mode_q <= MODE_XFER;
                end else begin
                    mode_q <= MODE_HBLANK;
                end

                if (line_end) begin
                    pix_cnt <= '0;
                end else if (take || pad) begin
                    pix_cnt <= pix_cnt + 8'd1;
                end

                if (take) begin
                    lcd_clkena <= 1'b1;
                    lcd_data   <= pix.pix_data;
                end else if (pad) begin
                    lcd_clkena <= 1'b1;
                    lcd_data   <= 2'b00;
                    underrun   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gb_lcd_stream_gen.sv
// Bench for gb_lcd_stream_gen: random mixer stalls and dot enables, checked
// every clock against a dot-position reference model.
module tb_gb_lcd_stream_gen;
    import gb_lcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       lcd_on;
    logic [1:0] mode;
    logic       lcd_clkena;
    logic [1:0] lcd_data;
    logic [7:0] ly;
    logic       vblank_irq;
    logic       underrun;

    gb_lcd_stream_gen_if pix_if ();

    gb_lcd_stream_gen dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .lcd_on     (lcd_on),
        .pix        (pix_if),
        .mode       (mode),
        .lcd_clkena (lcd_clkena),
        .lcd_data   (lcd_data),
        .ly         (ly),
        .vblank_irq (vblank_irq),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: m_t = dots elapsed since the LCD was (re)started.
    int         m_t;
    int         m_pcnt;
    bit         m_under;
    bit         seg_ok;
    logic [1:0] exp_mode;
    logic [1:0] exp_data;
    logic [7:0] exp_ly;
    logic       exp_stb;
    logic       exp_irq;
    int         dut_line_stb;
    int         irq_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_t      = 0;
        m_pcnt   = 0;
        m_under  = 1'b0;
        seg_ok   = 1'b0;
        exp_mode = 2'b00;
        exp_data = 2'b00;
        exp_ly   = 8'd0;
        exp_stb  = 1'b0;
        exp_irq  = 1'b0;
    endtask

    function automatic bit model_ready(input bit lo, input bit c, input bit v);
        int dot;
        int line;
        dot  = m_t % LINE_DOTS;
        line = (m_t / LINE_DOTS) % LINES;
        return lo && c && v && (line < VIS_LINES) && (dot >= OAM_DOTS) && (m_pcnt < H_PIXELS);
    endfunction

    task automatic model_update(input bit lo, input bit c, input bit v, input logic [1:0] d);
        int dot;
        int line;
        int prev;
        exp_stb = 1'b0;
        exp_irq = 1'b0;
        if (!lo) begin
            model_reset();
        end else if (c) begin
            dot  = m_t % LINE_DOTS;
            line = (m_t / LINE_DOTS) % LINES;
            if (dot == 0) begin
                if (seg_ok) begin
                    prev = (line + LINES - 1) % LINES;
                    chk("line_strobes", dut_line_stb, (prev < VIS_LINES) ? H_PIXELS : 0);
                end
                seg_ok       = 1'b1;
                dut_line_stb = 0;
                m_pcnt       = 0;
            end
            if (line >= VIS_LINES) begin
                exp_mode = 2'b01;
            end else if (dot < OAM_DOTS) begin
                exp_mode = 2'b10;
            end else if (m_pcnt < H_PIXELS) begin
                exp_mode = 2'b11;
                if (v) begin
                    exp_stb  = 1'b1;
                    exp_data = d;
                    m_pcnt++;
                end else if (dot >= PAD_START) begin
                    exp_stb  = 1'b1;
                    exp_data = 2'b00;
                    m_pcnt++;
                    m_under  = 1'b1;
                end
            end else begin
                exp_mode = 2'b00;
            end
            exp_irq = (line == VIS_LINES) && (dot == 0);
            exp_ly  = 8'(line);
            m_t     = (m_t + 1) % (LINE_DOTS * LINES);
        end
    endtask

    task automatic check_outputs();
        chk("mode", mode, exp_mode);
        chk("ly", ly, exp_ly);
        chk("lcd_clkena", lcd_clkena, exp_stb);
        chk("vblank_irq", vblank_irq, exp_irq);
        chk("underrun", underrun, m_under);
        if (exp_stb) chk("lcd_data", lcd_data, exp_data);
        if (lcd_clkena === 1'b1) dut_line_stb++;
        if (vblank_irq === 1'b1) irq_seen++;
    endtask

    task automatic step(input bit lo, input bit c, input bit v, input logic [1:0] d);
        @(negedge clk);
        check_outputs();
        lcd_on           = lo;
        ce               = c;
        pix_if.pix_valid = v;
        pix_if.pix_data  = d;
        #1;
        chk("pix_ready", pix_if.pix_ready, model_ready(lo, c, v));
        model_update(lo, c, v, d);
    endtask

    task automatic async_reset_mid();
        @(posedge clk);
        #2;
        check_outputs();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        ce    = 1'b0;
        reset = 1'b0;
    endtask

    function automatic bit coin(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic logic [1:0] rpix();
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        reset            = 1'b1;
        lcd_on           = 1'b0;
        ce               = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = 2'b00;
        dut_line_stb     = 0;
        irq_seen         = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // LCD off: nothing moves even with ce and valid pixels.
        repeat (3) step(1'b0, 1'b1, 1'b1, rpix());

        // Always-valid mixer, then an asynchronous reset in line 1.
        for (int i = 0; i < LINE_DOTS + 100; i++) step(1'b1, 1'b1, 1'b1, rpix());
        async_reset_mid();

        // Two full-rate lines, two 50%-stall lines, one starved (pad) line.
        for (int i = 0; i < 2 * LINE_DOTS; i++) step(1'b1, 1'b1, 1'b1, rpix());
        for (int i = 0; i < 2 * LINE_DOTS; i++) step(1'b1, 1'b1, coin(50), rpix());
        for (int i = 0; i < LINE_DOTS; i++) step(1'b1, 1'b1, 1'b0, rpix());
        step(1'b1, 1'b1, coin(80), rpix());
        chk("underrun_sticky", underrun, 1'b1);

        // Run to line 20 dot 200, then drop lcd_on together with ce.
        for (int i = 0; i < 20000 && m_t != 20 * LINE_DOTS + 200; i++)
            step(1'b1, 1'b1, coin(80), rpix());
        step(1'b0, 1'b1, 1'b1, rpix());
        for (int i = 0; i < 3; i++) step(1'b0, coin(50), coin(50), rpix());

        // Re-enable: one line with ce every 4th clk, then the rest of the frame.
        irq_seen = 0;
        for (int i = 0; i < 4 * LINE_DOTS; i++) step(1'b1, (i % 4) == 0, coin(70), rpix());
        for (int i = 0; i < (LINES - 1) * LINE_DOTS + 10; i++) step(1'b1, 1'b1, coin(90), rpix());
        @(negedge clk);
        check_outputs();
        chk("vblank_irq_count", irq_seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
